// File: rtl/operand_fetch.sv
// rtl/operand_fetch.sv - two-operand fetch sequencer feeding the ALU
module operand_fetch #(
    parameter int SIZE = 16
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            START,
    input  logic [1:0]      AS,
    input  logic            AD,
    input  logic            BW,
    input  logic [3:0]      SREG,
    input  logic [3:0]      DREG,
    output logic [3:0]      RF_RADDR,
    input  logic [SIZE-1:0] RF_RDATA,
    output logic            RF_WE,
    output logic [3:0]      RF_WADDR,
    output logic [SIZE-1:0] RF_WDATA,
    output logic            MEM_REQ,
    output logic [SIZE-1:0] MEM_ADDR,
    input  logic            MEM_ACK,
    input  logic [SIZE-1:0] MEM_RDATA,
    output logic [SIZE-1:0] SRC,
    output logic [SIZE-1:0] DST,
    output logic [SIZE-1:0] DST_ADDR,
    output logic            DST_MEM,
    output logic            OPS_VALID,
    output logic            BUSY
);

    typedef enum logic [2:0] {
        IDLE, SRC_EXT, SRC_MEM, DST_EXT, DST_MEM_RD, DONE
    } state_t;

    state_t state, state_nx;

    logic [1:0]      as_q;
    logic            ad_q, bw_q;
    logic [3:0]      sreg_q, dreg_q;
    logic [SIZE-1:0] x_q, src_t, dst_t, dst_addr_t;
    logic [SIZE-1:0] src_o, dst_o, dst_addr_o;
    logic            dst_mem_o;
    logic            wb_pend, ack_q;
    logic [3:0]      wb_addr;
    logic [SIZE-1:0] wb_data;

    logic            cg_hit;
    logic [SIZE-1:0] cg_val;
    logic            stall, valid, captured;
    logic            ld_src, ld_x, ld_dst, wb_set;
    logic [SIZE-1:0] src_nx, base;
    logic [3:0]      wb_addr_nx;
    logic [SIZE-1:0] wb_data_nx;

    function automatic logic [SIZE-1:0] lo_byte(input logic [SIZE-1:0] w);
        return {{(SIZE-8){1'b0}}, w[7:0]};
    endfunction

    function automatic logic [SIZE-1:0] mem_operand(input logic [SIZE-1:0] w,
                                                    input logic odd, input logic bw);
        if (!bw)
            return w;
        return odd ? {{(SIZE-8){1'b0}}, w[15:8]} : lo_byte(w);
    endfunction

    // R3 always generates a constant; R2 only in the two indirect modes
    always_comb begin
        cg_hit = 1'b0;
        cg_val = '0;
        if (SREG == 4'd3) begin
            cg_hit = 1'b1;
            case (AS)
                2'b00:   cg_val = '0;
                2'b01:   cg_val = SIZE'(1);
                2'b10:   cg_val = SIZE'(2);
                default: cg_val = '1;
            endcase
        end else if (SREG == 4'd2 && AS[1]) begin
            cg_hit = 1'b1;
            cg_val = AS[0] ? SIZE'(8) : SIZE'(4);
        end
    end

    // A pending register write or the cycle right after a data capture holds off new requests
    assign stall    = wb_pend || ack_q;
    assign captured = MEM_REQ && MEM_ACK;

    always_comb begin
        state_nx   = state;
        RF_RADDR   = 4'd0;
        MEM_REQ    = 1'b0;
        MEM_ADDR   = '0;
        base       = '0;
        ld_src     = 1'b0;
        src_nx     = '0;
        ld_x       = 1'b0;
        ld_dst     = 1'b0;
        wb_set     = 1'b0;
        wb_addr_nx = 4'd0;
        wb_data_nx = '0;
        valid      = 1'b0;
        case (state)
            IDLE: begin
                RF_RADDR = SREG;
                if (START) begin
                    if (AS == 2'b00 || cg_hit) begin
                        ld_src   = 1'b1;
                        src_nx   = cg_hit ? (BW ? lo_byte(cg_val) : cg_val)
                                          : (BW ? lo_byte(RF_RDATA) : RF_RDATA);
                        state_nx = AD ? DST_EXT : DONE;
                    end else if (AS == 2'b01) begin
                        state_nx = SRC_EXT;
                    end else begin
                        state_nx = SRC_MEM;
                    end
                end
            end
            SRC_EXT, DST_EXT: begin
                RF_RADDR = 4'd0;
                MEM_ADDR = RF_RDATA;
                MEM_REQ  = !stall;
                if (MEM_REQ && MEM_ACK) begin
                    ld_x       = 1'b1;
                    wb_set     = 1'b1;
                    wb_addr_nx = 4'd0;
                    wb_data_nx = RF_RDATA + SIZE'(2);
                    state_nx   = (state == SRC_EXT) ? SRC_MEM : DST_MEM_RD;
                end
            end
            SRC_MEM: begin
                RF_RADDR = sreg_q;
                base     = (as_q == 2'b01 && sreg_q == 4'd2) ? '0 : RF_RDATA;
                MEM_ADDR = base + ((as_q == 2'b01) ? x_q : '0);
                MEM_REQ  = !stall;
                if (MEM_REQ && MEM_ACK) begin
                    ld_src = 1'b1;
                    src_nx = mem_operand(MEM_RDATA, MEM_ADDR[0], bw_q);
                    if (as_q == 2'b11) begin
                        // immediate (R0) always steps a full word
                        wb_set     = 1'b1;
                        wb_addr_nx = sreg_q;
                        wb_data_nx = RF_RDATA + ((bw_q && sreg_q != 4'd0) ? SIZE'(1) : SIZE'(2));
                    end
                    state_nx = ad_q ? DST_EXT : DONE;
                end
            end
            DST_MEM_RD: begin
                RF_RADDR = dreg_q;
                base     = (dreg_q == 4'd2) ? '0 : RF_RDATA;
                MEM_ADDR = base + x_q;
                MEM_REQ  = !stall;
                if (MEM_REQ && MEM_ACK) begin
                    ld_dst   = 1'b1;
                    state_nx = DONE;
                end
            end
            DONE: begin
                RF_RADDR = dreg_q;
                if (!wb_pend) begin
                    valid    = 1'b1;
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state      <= IDLE;
            as_q       <= 2'b00;
            ad_q       <= 1'b0;
            bw_q       <= 1'b0;
            sreg_q     <= 4'd0;
            dreg_q     <= 4'd0;
            x_q        <= '0;
            src_t      <= '0;
            dst_t      <= '0;
            dst_addr_t <= '0;
            src_o      <= '0;
            dst_o      <= '0;
            dst_addr_o <= '0;
            dst_mem_o  <= 1'b0;
            wb_pend    <= 1'b0;
            wb_addr    <= 4'd0;
            wb_data    <= '0;
            ack_q      <= 1'b0;
        end else begin
            state   <= state_nx;
            ack_q   <= captured;
            wb_pend <= wb_set;
            if (wb_set) begin
                wb_addr <= wb_addr_nx;
                wb_data <= wb_data_nx;
            end
            if (state == IDLE && START) begin
                as_q   <= AS;
                ad_q   <= AD;
                bw_q   <= BW;
                sreg_q <= SREG;
                dreg_q <= DREG;
            end
            if (ld_x)
                x_q <= MEM_RDATA;
            if (ld_src)
                src_t <= src_nx;
            if (ld_dst) begin
                dst_t      <= mem_operand(MEM_RDATA, MEM_ADDR[0], bw_q);
                dst_addr_t <= MEM_ADDR;
            end
            if (valid) begin
                src_o      <= SRC;
                dst_o      <= DST;
                dst_addr_o <= DST_ADDR;
                dst_mem_o  <= DST_MEM;
            end
        end
    end

    // During the valid cycle a register destination is read straight from the file
    assign SRC       = valid ? src_t : src_o;
    assign DST       = valid ? (ad_q ? dst_t : (bw_q ? lo_byte(RF_RDATA) : RF_RDATA)) : dst_o;
    assign DST_ADDR  = valid ? (ad_q ? dst_addr_t : '0) : dst_addr_o;
    assign DST_MEM   = valid ? ad_q : dst_mem_o;
    assign OPS_VALID = valid;
    assign BUSY      = (state != IDLE);
    assign RF_WE     = wb_pend;
    assign RF_WADDR  = wb_addr;
    assign RF_WDATA  = wb_data;

endmodule
